flash_reader: RTL

FLASH_READER -- requirements
Module: flash_reader

---
 rtl/flash_reader_if.sv | 30 +++
 rtl/flash_reader.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/flash_reader_if.sv
// Request/stream/serial-flash signal bundle for flash_reader.
// master = requester and flash side, slave = the controller.
interface flash_reader_if #(
  parameter int unsigned LENGTH_WIDTH = 16
);
  logic                    request;
  logic [23:0]             request_address;
  logic [LENGTH_WIDTH-1:0] request_length;
  logic                    abort;
  logic                    ready;
  logic                    byte_valid;
  logic [7:0]              byte_data;
  logic                    done;
  logic                    flash_clock;
  logic                    flash_select;
  logic                    flash_data_out;
  logic                    flash_data_in;

  modport master (
    output request, request_address, request_length, abort, flash_data_in,
    input  ready, byte_valid, byte_data, done,
    input  flash_clock, flash_select, flash_data_out
  );

  modport slave (
    input  request, request_address, request_length, abort, flash_data_in,
    output ready, byte_valid, byte_data, done,
    output flash_clock, flash_select, flash_data_out
  );
endinterface

// File: rtl/flash_reader.sv
// Serial flash read controller: sends opcode + 24-bit address at clock/2,
// then streams length bytes back, MSB first, with abort and deselect timing.
module flash_reader #(
  parameter logic [7:0]  READ_COMMAND = 8'h03,
  parameter int unsigned LENGTH_WIDTH = 16
) (
  input  logic           clock,
  input  logic           reset,
  flash_reader_if.slave  bus
);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_SELECT   = 3'd1;
  localparam logic [2:0] ST_SHIFT    = 3'd2;
  localparam logic [2:0] ST_END      = 3'd3;
  localparam logic [2:0] ST_DESELECT = 3'd4;

  localparam int unsigned TX_BITS   = 32;
  localparam int unsigned CNT_W     = 6;
  // tx_count saturates one past TX_BITS to mark the data phase
  localparam logic [CNT_W-1:0] TX_LAST = CNT_W'(TX_BITS);
  localparam logic [CNT_W-1:0] RX_MODE = CNT_W'(TX_BITS + 1);

  logic [2:0]              state_q, state_n;
  logic [31:0]             tx_shift_q, tx_shift_n;
  logic [CNT_W-1:0]        tx_count_q, tx_count_n;
  logic [6:0]              rx_shift_q, rx_shift_n;
  logic [2:0]              rx_bits_q, rx_bits_n;
  logic [LENGTH_WIDTH-1:0] remaining_q, remaining_n;
  logic                    hold_q, hold_n;
  logic                    ready_q, ready_n;
  logic                    byte_valid_q, byte_valid_n;
  logic [7:0]              byte_data_q, byte_data_n;
  logic                    done_q, done_n;
  logic                    fclk_q, fclk_n;
  logic                    fsel_q, fsel_n;
  logic                    mosi_q, mosi_n;

  assign bus.ready          = ready_q;
  assign bus.byte_valid     = byte_valid_q;
  assign bus.byte_data      = byte_data_q;
  assign bus.done           = done_q;
  assign bus.flash_clock    = fclk_q;
  assign bus.flash_select   = fsel_q;
  assign bus.flash_data_out = mosi_q;

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      tx_shift_q   <= '0;
      tx_count_q   <= '0;
      rx_shift_q   <= '0;
      rx_bits_q    <= '0;
      remaining_q  <= '0;
      hold_q       <= 1'b0;
      ready_q      <= 1'b1;
      byte_valid_q <= 1'b0;
      byte_data_q  <= '0;
      done_q       <= 1'b0;
      fclk_q       <= 1'b0;
      fsel_q       <= 1'b1;
      mosi_q       <= 1'b0;
    end else begin
      state_q      <= state_n;
      tx_shift_q   <= tx_shift_n;
      tx_count_q   <= tx_count_n;
      rx_shift_q   <= rx_shift_n;
      rx_bits_q    <= rx_bits_n;
      remaining_q  <= remaining_n;
      hold_q       <= hold_n;
      ready_q      <= ready_n;
      byte_valid_q <= byte_valid_n;
      byte_data_q  <= byte_data_n;
      done_q       <= done_n;
      fclk_q       <= fclk_n;
      fsel_q       <= fsel_n;
      mosi_q       <= mosi_n;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_n      = state_q;
    tx_shift_n   = tx_shift_q;
    tx_count_n   = tx_count_q;
    rx_shift_n   = rx_shift_q;
    rx_bits_n    = rx_bits_q;
    remaining_n  = remaining_q;
    hold_n       = hold_q;
    ready_n      = ready_q;
    byte_valid_n = 1'b0;
    byte_data_n  = byte_data_q;
    done_n       = 1'b0;
    fclk_n       = fclk_q;
    fsel_n       = fsel_q;
    mosi_n       = mosi_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.request && (bus.request_length != '0)) begin
          state_n     = ST_SELECT;
          ready_n     = 1'b0;
          fsel_n      = 1'b0;
          fclk_n      = 1'b0;
          mosi_n      = 1'b0;
          tx_shift_n  = {READ_COMMAND, bus.request_address};
          tx_count_n  = '0;
          rx_bits_n   = '0;
          remaining_n = bus.request_length;
        end
      end

      ST_SELECT: begin
        if (bus.abort) begin
          state_n = ST_END;
        end else begin
          state_n    = ST_SHIFT;
          mosi_n     = tx_shift_q[31];
          tx_shift_n = {tx_shift_q[30:0], 1'b0};
          tx_count_n = CNT_W'(1);
        end
      end

      ST_SHIFT: begin
        if (!fclk_q) begin
          // Rising edge: sample data bits; a byte finishing here survives abort
          fclk_n = !bus.abort;
          if (bus.abort) state_n = ST_END;
          if (tx_count_q == RX_MODE) begin
            rx_shift_n = {rx_shift_q[5:0], bus.flash_data_in};
            rx_bits_n  = rx_bits_q + 3'd1;
            if (rx_bits_q == 3'd7) begin
              byte_data_n  = {rx_shift_q, bus.flash_data_in};
              byte_valid_n = 1'b1;
              remaining_n  = remaining_q - LENGTH_WIDTH'(1);
            end
          end
        end else begin
          fclk_n = 1'b0;
          if (bus.abort || (remaining_q == '0)) begin
            state_n = ST_END;
            mosi_n  = 1'b0;
          end else if (tx_count_q < TX_LAST) begin
            mosi_n     = tx_shift_q[31];
            tx_shift_n = {tx_shift_q[30:0], 1'b0};
            tx_count_n = tx_count_q + CNT_W'(1);
          end else begin
            mosi_n     = 1'b0;
            tx_count_n = RX_MODE;
          end
        end
      end

      ST_END: begin
        state_n = ST_DESELECT;
        fsel_n  = 1'b1;
        fclk_n  = 1'b0;
        mosi_n  = 1'b0;
        done_n  = 1'b1;
        hold_n  = 1'b0;
      end

      ST_DESELECT: begin
        if (hold_q) begin
          state_n = ST_IDLE;
          ready_n = 1'b1;
        end else begin
          hold_n = 1'b1;
        end
      end

      default: begin
        state_n = ST_IDLE;
        ready_n = 1'b1;
        fsel_n  = 1'b1;
        fclk_n  = 1'b0;
      end
    endcase
  end

endmodule
